// File: rtl/div_mae_monitor.sv
// Error-metric monitor for approximate vs exact 16/8 divider rows: accumulates
// |q error|, max error and mismatch counts over 2^LOG2_N samples, then reports MAE.
module div_mae_monitor #(
    parameter int LOG2_N = 8,
    parameter int SUM_W  = 8 + LOG2_N
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          q_apx,
    input  logic [7:0]          r_apx,
    input  logic [7:0]          q_ref,
    input  logic [7:0]          r_ref,
    output logic                busy,
    output logic                done,
    output logic [7:0]          mae,
    output logic [SUM_W-1:0]    sum_abs_err,
    output logic [7:0]          max_abs_err,
    output logic [LOG2_N:0]     q_err_cnt,
    output logic [LOG2_N:0]     r_err_cnt
);

    localparam int DATA_W = 8;
    localparam logic [LOG2_N:0] CNT_LAST = {1'b0, {LOG2_N{1'b1}}};
    localparam logic [LOG2_N:0] CNT_ONE  = {{LOG2_N{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LOG2_N:0]        r_cnt;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_clear;

    logic [DATA_W-1:0]      r_abs_err_p1;
    logic                   r_q_mis_p1;
    logic                   r_r_mis_p1;
    logic                   r_vld_p1;

    logic [SUM_W-1:0]       r_sum_p2;
    logic [DATA_W-1:0]      r_max_p2;
    logic [LOG2_N:0]        r_q_cnt_p2;
    logic [LOG2_N:0]        r_r_cnt_p2;
    logic [DATA_W-1:0]      r_mae_p2;
    logic [SUM_W-1:0]       w_sum_nxt;

    // Magnitude of a 9-bit signed difference; always fits in DATA_W bits.
    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] d;
        logic signed [DATA_W:0] m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = d[DATA_W] ? -d : d;
        return m[DATA_W-1:0];
    endfunction

    assign w_accept = in_valid && (r_state == S_RUN);
    assign w_last   = w_accept && (r_cnt == CNT_LAST);
    assign w_clear  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  if (start)  w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear)
                r_cnt <= '0;
            else if (w_accept)
                r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Stage 1: per-sample error terms, captured only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_vld_p1 <= 1'b0;
        else
            r_vld_p1 <= w_accept;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_abs_err_p1 <= abs_diff(q_apx, q_ref);
            r_q_mis_p1   <= (q_apx != q_ref);
            r_r_mis_p1   <= (r_apx != r_ref);
        end
    end

    // Stage 2: window accumulators; mae samples the final sum as DRAIN retires
    assign w_sum_nxt = r_sum_p2 + (r_vld_p1 ? {{(SUM_W-DATA_W){1'b0}}, r_abs_err_p1}
                                            : {SUM_W{1'b0}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_p2   <= '0;
            r_max_p2   <= '0;
            r_q_cnt_p2 <= '0;
            r_r_cnt_p2 <= '0;
            r_mae_p2   <= '0;
        end else if (w_clear) begin
            r_sum_p2   <= '0;
            r_max_p2   <= '0;
            r_q_cnt_p2 <= '0;
            r_r_cnt_p2 <= '0;
            r_mae_p2   <= '0;
        end else begin
            if (r_vld_p1) begin
                r_sum_p2   <= w_sum_nxt;
                r_max_p2   <= (r_abs_err_p1 > r_max_p2) ? r_abs_err_p1 : r_max_p2;
                r_q_cnt_p2 <= r_q_cnt_p2 + {{LOG2_N{1'b0}}, r_q_mis_p1};
                r_r_cnt_p2 <= r_r_cnt_p2 + {{LOG2_N{1'b0}}, r_r_mis_p1};
            end
            if (r_state == S_DRAIN)
                r_mae_p2 <= w_sum_nxt[LOG2_N +: DATA_W];
        end
    end

    assign in_ready    = (r_state == S_RUN);
    assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign mae         = r_mae_p2;
    assign sum_abs_err = r_sum_p2;
    assign max_abs_err = r_max_p2;
    assign q_err_cnt   = r_q_cnt_p2;
    assign r_err_cnt   = r_r_cnt_p2;

endmodule
